// File: rtl/prs_counter_bank.sv
// Multi-channel pulse counter bank with synchronised inputs, rising-edge counting,
// per-channel enable, sticky overflow flags, atomic snapshot and ready/valid readout.
// Build option: define PRS_CNT_SATURATE_EN to make counters saturate at max instead of wrapping.
module prs_counter_bank #(
  parameter int unsigned NUM_CH      = 16,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned SYNC_STAGES = 2,
  // Derived from NUM_CH; not meant to be overridden.
  parameter int unsigned IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_CH-1:0]    i_cnt_channels,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd_op,
  input  logic [NUM_CH-1:0]    i_cmd_mask,
  output logic                 o_cmd_ready,
  output logic [CNT_WIDTH-1:0] o_rd_data,
  output logic                 o_rd_ovf,
  output logic [IDX_W-1:0]     o_rd_idx,
  output logic                 o_rd_valid,
  output logic                 o_rd_last,
  input  logic                 i_rd_ready,
  output logic [NUM_CH-1:0]    o_ovf,
  output logic                 o_busy
);

  typedef enum logic [0:0] {StIdle, StStream} state_e;

  localparam logic [1:0]           OpSetEn     = 2'b00;
  localparam logic [1:0]           OpSnap      = 2'b01;
  localparam logic [1:0]           OpClear     = 2'b10;
  localparam logic [1:0]           OpSnapClear = 2'b11;
  localparam logic [CNT_WIDTH-1:0] CntMax      = '1;
  localparam logic [IDX_W-1:0]     IdxLast     = IDX_W'(NUM_CH - 1);

  logic [NUM_CH-1:0]    sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0]    sync_d [SYNC_STAGES];
  logic [NUM_CH-1:0]    hist_q, hist_d;
  logic [NUM_CH-1:0]    pulse_edge;
  logic [NUM_CH-1:0]    en_q, en_d;
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0]    ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0] shadow_q [NUM_CH];
  logic [CNT_WIDTH-1:0] shadow_d [NUM_CH];
  logic [NUM_CH-1:0]    shovf_q, shovf_d;
  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;

  logic                 cmd_accept;
  logic                 do_snap;
  logic                 do_set_en;
  logic [NUM_CH-1:0]    clr_mask;

  assign cmd_accept = i_cmd_valid & (state_q == StIdle);
  assign do_snap    = cmd_accept & ((i_cmd_op == OpSnap) | (i_cmd_op == OpSnapClear));
  assign do_set_en  = cmd_accept & (i_cmd_op == OpSetEn);
  assign clr_mask   = (cmd_accept & ((i_cmd_op == OpClear) | (i_cmd_op == OpSnapClear))) ?
                      i_cmd_mask : '0;

  // Synchroniser chain and edge history; history tracks the input even when disabled.
  always_comb begin
    sync_d[0] = i_cnt_channels;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
    hist_d     = sync_q[SYNC_STAGES-1];
    pulse_edge = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  // Counter and sticky overflow next state; a clear keeps a same-cycle edge as a count of 1.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (pulse_edge[k] & en_q[k]) begin
`ifdef PRS_CNT_SATURATE_EN
        if (cnt_q[k] == CntMax) begin
          ovf_d[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
        end
`else
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
        if (cnt_q[k] == CntMax) begin
          ovf_d[k] = 1'b1;
        end
`endif
      end
      if (clr_mask[k]) begin
        cnt_d[k] = (pulse_edge[k] & en_q[k]) ? CNT_WIDTH'(1) : '0;
        ovf_d[k] = 1'b0;
      end
    end
  end

  // Enable register and snapshot capture of pre-edge counter values.
  always_comb begin
    en_d     = do_set_en ? i_cmd_mask : en_q;
    shadow_d = shadow_q;
    shovf_d  = shovf_q;
    if (do_snap) begin
      shadow_d = cnt_q;
      shovf_d  = ovf_q;
    end
  end

  // Readout FSM: IDLE accepts commands, STREAM walks the snapshot one word per handshake.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (do_snap) begin
          state_d = StStream;
          idx_d   = '0;
        end
      end
      StStream: begin
        if (i_rd_ready) begin
          if (idx_q == IdxLast) begin
            state_d = StIdle;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q   <= '{default: '0};
      hist_q   <= '0;
      en_q     <= '0;
      cnt_q    <= '{default: '0};
      ovf_q    <= '0;
      shadow_q <= '{default: '0};
      shovf_q  <= '0;
      state_q  <= StIdle;
      idx_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      hist_q   <= hist_d;
      en_q     <= en_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      shadow_q <= shadow_d;
      shovf_q  <= shovf_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
    end
  end

  // Outputs decoded purely from registered state.
  assign o_cmd_ready = (state_q == StIdle);
  assign o_busy      = (state_q == StStream);
  assign o_rd_valid  = (state_q == StStream);
  assign o_rd_idx    = idx_q;
  assign o_rd_data   = shadow_q[idx_q];
  assign o_rd_ovf    = shovf_q[idx_q];
  assign o_rd_last   = (idx_q == IdxLast);
  assign o_ovf       = ovf_q;

endmodule

// File: tb/tb_prs_counter_bank.sv
// Self-checking bench for prs_counter_bank: directed stimulus, a cycle-level reference
// model of the pin-to-count behaviour, and literal expectations for key scenarios.
module tb_prs_counter_bank;

  localparam int NUM_CH      = 16;
  localparam int CNT_WIDTH   = 8;
  localparam int SYNC_STAGES = 2;
  localparam int IDX_W       = 4;

  localparam logic [1:0] SET_EN = 2'b00, SNAP = 2'b01, CLEAR = 2'b10, SNAP_CLEAR = 2'b11;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic [NUM_CH-1:0]    i_cnt_channels = '0;
  logic                 i_cmd_valid = 1'b0;
  logic [1:0]           i_cmd_op = 2'b00;
  logic [NUM_CH-1:0]    i_cmd_mask = '0;
  logic                 o_cmd_ready;
  logic [CNT_WIDTH-1:0] o_rd_data;
  logic                 o_rd_ovf;
  logic [IDX_W-1:0]     o_rd_idx;
  logic                 o_rd_valid;
  logic                 o_rd_last;
  logic                 i_rd_ready = 1'b0;
  logic [NUM_CH-1:0]    o_ovf;
  logic                 o_busy;

  int n_vec = 0;
  int n_bad = 0;

  prs_counter_bank #(
    .NUM_CH     (NUM_CH),
    .CNT_WIDTH  (CNT_WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_cnt_channels(i_cnt_channels),
    .i_cmd_valid   (i_cmd_valid),
    .i_cmd_op      (i_cmd_op),
    .i_cmd_mask    (i_cmd_mask),
    .o_cmd_ready   (o_cmd_ready),
    .o_rd_data     (o_rd_data),
    .o_rd_ovf      (o_rd_ovf),
    .o_rd_idx      (o_rd_idx),
    .o_rd_valid    (o_rd_valid),
    .o_rd_last     (o_rd_last),
    .i_rd_ready    (i_rd_ready),
    .o_ovf         (o_ovf),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // pin_hist[j] = pin vector sampled j clock edges ago.
  logic [NUM_CH-1:0]    pin_hist [1:SYNC_STAGES+1];
  int unsigned          m_cnt    [NUM_CH];
  int unsigned          m_shadow [NUM_CH];
  logic [NUM_CH-1:0]    m_ovf, m_shovf, m_en;
  bit                   m_stream;
  int                   m_idx;
  localparam int unsigned MaxCnt = (1 << CNT_WIDTH) - 1;

  task automatic model_reset();
    for (int j = 1; j <= SYNC_STAGES + 1; j++) pin_hist[j] = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_cnt[k]    = 0;
      m_shadow[k] = 0;
    end
    m_ovf = '0; m_shovf = '0; m_en = '0; m_stream = 0; m_idx = 0;
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0] rise;
    bit acc, snap, clr, counted;
    // A pin rise is counted SYNC_STAGES edges after it was first sampled.
    rise = pin_hist[SYNC_STAGES] & ~pin_hist[SYNC_STAGES+1];
    acc  = i_cmd_valid && !m_stream;
    snap = acc && (i_cmd_op == SNAP || i_cmd_op == SNAP_CLEAR);
    clr  = acc && (i_cmd_op == CLEAR || i_cmd_op == SNAP_CLEAR);
    if (snap) begin
      for (int k = 0; k < NUM_CH; k++) m_shadow[k] = m_cnt[k];
      m_shovf = m_ovf;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      counted = rise[k] && m_en[k];
      if (counted) begin
        if (m_cnt[k] == MaxCnt) begin
          m_ovf[k] = 1'b1;
`ifndef PRS_CNT_SATURATE_EN
          m_cnt[k] = 0;
`endif
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
      if (clr && i_cmd_mask[k]) begin
        m_cnt[k] = counted ? 1 : 0;
        m_ovf[k] = 1'b0;
      end
    end
    if (m_stream && i_rd_ready) begin
      if (m_idx == NUM_CH - 1) m_stream = 0;
      else m_idx++;
    end
    if (snap) begin
      m_stream = 1;
      m_idx    = 0;
    end
    if (acc && i_cmd_op == SET_EN) m_en = i_cmd_mask;
    for (int j = SYNC_STAGES + 1; j >= 2; j--) pin_hist[j] = pin_hist[j-1];
    pin_hist[1] = i_cnt_channels;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge i_clk or negedge i_rst_n);
      if (!i_rst_n) model_reset();
      else model_step();
    end
  end

  // Compare process: every cycle out of reset, on the falling edge.
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        check("cmd_ready", o_cmd_ready, !m_stream);
        check("busy", o_busy, m_stream);
        check("rd_valid", o_rd_valid, m_stream);
        check("ovf_live", o_ovf, m_ovf);
        if (m_stream) begin
          check("rd_data", o_rd_data, m_shadow[m_idx]);
          check("rd_ovf", o_rd_ovf, m_shovf[m_idx]);
          check("rd_idx", o_rd_idx, m_idx);
          check("rd_last", o_rd_last, m_idx == NUM_CH - 1);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [CNT_WIDTH-1:0] got     [NUM_CH];
  logic                 got_ovf [NUM_CH];
  int                   last_idx;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [NUM_CH-1:0] mask);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_mask  = mask;
    tick(1);
    i_cmd_valid = 1'b0;
  endtask

  task automatic pulses(input logic [NUM_CH-1:0] m, input int n);
    repeat (n) begin
      i_cnt_channels = i_cnt_channels | m;
      tick(2);
      i_cnt_channels = i_cnt_channels & ~m;
      tick(2);
    end
  endtask

  // Drain the remainder of a stream with ready held high; bounded by a cycle budget.
  task automatic drain();
    bit done;
    done = 0;
    last_idx = -1;
    i_rd_ready = 1'b1;
    for (int c = 0; c < NUM_CH + 4 && !done; c++) begin
      @(negedge i_clk);
      if (o_rd_valid) begin
        got[o_rd_idx]     = o_rd_data;
        got_ovf[o_rd_idx] = o_rd_ovf;
        if (o_rd_last) begin
          last_idx = o_rd_idx;
          done     = 1;
        end
      end
      @(posedge i_clk);
      #1;
    end
    i_rd_ready = 1'b0;
    check("stream_ends", done, 1'b1);
  endtask

  task automatic snap_read();
    for (int k = 0; k < NUM_CH; k++) begin
      got[k]     = '1;
      got_ovf[k] = 1'bx;
    end
    issue(SNAP, '0);
    drain();
  endtask

  function automatic int nonzero_words();
    int n = 0;
    for (int k = 0; k < NUM_CH; k++) if (got[k] != 0 || got_ovf[k] != 0) n++;
    return n;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    tick(3);
    check("reset_cmd_ready", o_cmd_ready, 1'b1);
    check("reset_rd_valid", o_rd_valid, 1'b0);
    check("reset_busy", o_busy, 1'b0);
    check("reset_ovf", o_ovf, '0);
    i_rst_n = 1'b1;
    tick(2);

    // Only ch0 enabled; both ch0 and ch1 pulse five times.
    issue(SET_EN, 16'h0001);
    pulses(16'h0003, 5);
    tick(5);
    snap_read();
    check("en_ch0_count", got[0], 5);
    check("en_ch1_count", got[1], 0);
    check("en_nonzero_words", nonzero_words(), 1);
    check("en_last_idx", last_idx, NUM_CH - 1);

    // 257 pulses on an 8-bit counter.
    issue(SET_EN, 16'h0004);
    pulses(16'h0004, 257);
    tick(5);
    check("ovf_live_ch2", o_ovf[2], 1'b1);
    snap_read();
`ifdef PRS_CNT_SATURATE_EN
    check("ovf_ch2_count", got[2], 255);
`else
    check("ovf_ch2_count", got[2], 1);
`endif
    check("ovf_ch2_flag", got_ovf[2], 1'b1);
    issue(CLEAR, 16'h0004);
    snap_read();
    check("clr_ch2_count", got[2], 0);
    check("clr_ch2_flag", got_ovf[2], 1'b0);
    check("clr_ch0_kept", got[0], 5);

    // SNAP_CLEAR with a ch3 edge counted on the accept edge.
    issue(SET_EN, 16'h0008);
    pulses(16'h0008, 7);
    tick(5);
    i_cnt_channels[3] = 1'b1;
    tick(2);
    for (int k = 0; k < NUM_CH; k++) got[k] = '1;
    issue(SNAP_CLEAR, '1);
    drain();
    check("sc_shadow_ch3", got[3], 7);
    i_cnt_channels[3] = 1'b0;
    tick(5);

    // Stall mid-stream and try a CLEAR, which must be ignored.
    issue(SNAP, '0);
    i_rd_ready = 1'b1;
    tick(1);
    i_rd_ready  = 1'b0;
    i_cmd_valid = 1'b1;
    i_cmd_op    = CLEAR;
    i_cmd_mask  = '1;
    for (int c = 0; c < 2; c++) begin
      @(negedge i_clk);
      check("stall_idx", o_rd_idx, 1);
      check("stall_cmd_ready", o_cmd_ready, 1'b0);
      @(posedge i_clk);
      #1;
    end
    i_cmd_valid = 1'b0;
    drain();
    check("stall_last_idx", last_idx, NUM_CH - 1);
    check("stall_ready_after", o_cmd_ready, 1'b1);
    snap_read();
    check("sc_live_ch3", got[3], 1);

    // Reset after three words of a stream.
    issue(SNAP, '0);
    i_rd_ready = 1'b1;
    tick(3);
    i_rst_n = 1'b0;
    #2;
    check("rst_mid_valid", o_rd_valid, 1'b0);
    check("rst_mid_busy", o_busy, 1'b0);
    check("rst_mid_ready", o_cmd_ready, 1'b1);
    i_rd_ready = 1'b0;
    tick(2);
    i_rst_n = 1'b1;
    tick(1);
    snap_read();
    check("rst_snap_zero", nonzero_words(), 0);

    // Enable ch4 while its input is already high: only the later rise counts.
    i_cnt_channels[4] = 1'b1;
    tick(5);
    issue(SET_EN, 16'h0010);
    tick(3);
    i_cnt_channels[4] = 1'b0;
    tick(3);
    i_cnt_channels[4] = 1'b1;
    tick(3);
    i_cnt_channels[4] = 1'b0;
    tick(5);
    snap_read();
    check("en_high_ch4", got[4], 1);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
